// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multi_cycle_control_if;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Op,
        input  MemReady,
        output PCWrite,
        output PCWriteCond,
        output IorD,
        output MemRead,
        output MemWrite,
        output IRWrite,
        output MemtoReg,
        output RegWrite,
        output RegDst,
        output ALUSrcA,
        output PCSource,
        output ALUSrcB,
        output ALUOp,
        output Illegal,
        output State
    );

    modport slave (
        output Op,
        output MemReady,
        input  PCWrite,
        input  PCWriteCond,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        input  IRWrite,
        input  MemtoReg,
        input  RegWrite,
        input  RegDst,
        input  ALUSrcA,
        input  PCSource,
        input  ALUSrcB,
        input  ALUOp,
        input  Illegal,
        input  State
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Moore controller for a five-instruction multi-cycle MIPS-style datapath.
// Outputs decode from the registered state and are held at 0 while in reset.
module multi_cycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    multi_cycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_o;
    logic   mem_rdy;

    assign mem_rdy = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl    = '0;
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = mem_rdy;
                ctrl.pc_write  = mem_rdy;
                state_d        = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
                case (bus.Op)
                    OP_LW,
                    OP_SW:   state_d = MEMADR;
                    OP_RTYP: state_d = RTYPEEX;
                    OP_BEQ:  state_d = BEQEX;
                    OP_J:    state_d = JEX;
                    default: begin
                        state_d      = FETCH;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = mem_rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = FETCH;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_d        = mem_rdy ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
                state_d        = RTYPEWB;
            end
            RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = FETCH;
            end
            BEQEX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                state_d            = FETCH;
            end
            JEX: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
                state_d        = FETCH;
            end
            // Unencoded states recover silently to FETCH.
            default: begin
                ctrl    = '0;
                state_d = FETCH;
            end
        endcase
    end

    // Reset gates the outputs combinationally so FETCH strobes stay quiet.
    assign ctrl_o = reset_n ? ctrl : '0;

    assign bus.PCWrite     = ctrl_o.pc_write;
    assign bus.PCWriteCond = ctrl_o.pc_write_cond;
    assign bus.IorD        = ctrl_o.iord;
    assign bus.MemRead     = ctrl_o.mem_read;
    assign bus.MemWrite    = ctrl_o.mem_write;
    assign bus.IRWrite     = ctrl_o.ir_write;
    assign bus.MemtoReg    = ctrl_o.mem_to_reg;
    assign bus.RegWrite    = ctrl_o.reg_write;
    assign bus.RegDst      = ctrl_o.reg_dst;
    assign bus.ALUSrcA     = ctrl_o.alu_src_a;
    assign bus.PCSource    = ctrl_o.pc_source;
    assign bus.ALUSrcB     = ctrl_o.alu_src_b;
    assign bus.ALUOp       = ctrl_o.alu_op;
    assign bus.Illegal     = ctrl_o.illegal;
    assign bus.State       = state_q;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: MEM_HANDSHAKE, default 1, meaning 1 = honour MemReady and 0 = treat MemReady as constant 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 Op  input  6  opcode field of the instruction register; held stable by the datapath from DECODE onward.
REQ-005 MemReady  input  1  memory access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath strobes and selects.
REQ-007 PCSource  output  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-008 ALUSrcB  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-009 ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-010 Illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-011 State  output  4  current state encoding, for debug.

Function
REQ-012 The block SHALL be a Moore FSM with a registered state and these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, JEX=9.
REQ-013 Every output not listed for a state SHALL be 0 in that state.
REQ-014 FETCH SHALL drive:
- MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
- IRWrite=PCWrite=MemReady.
- Next state: DECODE if MemReady, else FETCH.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, with next state by Op:
- 100011 or 101011 -> MEMADR.
- 000000 -> RTYPEEX.
- 000100 -> BEQEX.
- 000010 -> JEX.
- Any other Op -> FETCH, with Illegal=1 for that DECODE cycle only.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD if Op=100011, else MEMWR.
REQ-017 MEMRD SHALL drive MemRead=1, IorD=1; it stays in MEMRD until MemReady=1, then goes to MEMWB.
REQ-018 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0 for exactly one cycle, then go to FETCH.
REQ-019 MEMWR SHALL drive MemWrite=1, IorD=1; it stays in MEMWR until MemReady=1, then goes to FETCH.
REQ-020 RTYPEEX SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RTYPEWB.
REQ-021 RTYPEWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-022 BEQEX SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-023 JEX SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-024 Instruction latency in cycles, with zero wait states, SHALL be:
- lw = 5.
- sw = 4.
- R-type = 4.
- beq = 3.
- j = 3.
Each memory wait cycle adds exactly one cycle.
REQ-025 An unencoded State value (10-15) SHALL force next state FETCH with all outputs 0; Illegal SHALL NOT pulse in that case.
REQ-026 With MEM_HANDSHAKE=0, FETCH, MEMRD and MEMWR SHALL each last exactly one cycle regardless of MemReady.
REQ-027 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-028 PCWrite and PCWriteCond SHALL never be 1 in the same cycle.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for clk, force State=FETCH.
REQ-030 While reset_n=0, all outputs SHALL be forced to 0, including MemRead and IRWrite.
REQ-031 Reset asserted mid-instruction, e.g. in MEMRD awaiting MemReady, SHALL abandon the instruction with no further RegWrite, MemWrite or PCWrite.
REQ-032 The first rising edge after reset_n rises SHALL evaluate FETCH; FETCH outputs SHALL be valid from reset_n deassertion.

Verification
REQ-033 lw, Op=100011, MemReady=1 always -> State sequence 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4.
REQ-034 sw, Op=101011, MemReady low for 3 cycles in MEMWR -> MemWrite=1, IorD=1 for 4 consecutive cycles, then FETCH; RegWrite is never 1.
REQ-035 beq, Op=000100 -> State sequence 0,1,8,0; PCWriteCond=1, ALUOp=01, PCSource=01 in state 8; j, Op=000010 -> State sequence 0,1,9,0 with PCWrite=1, PCSource=10.
REQ-036 Op=111111 at DECODE -> Illegal=1 for one cycle, next State=0, no write strobes asserted.
REQ-037 reset_n pulsed low asynchronously between edges while in MEMRD -> State=0 and all outputs 0 at once; after release, MemRead=1, IorD=0.
REQ-038 MEM_HANDSHAKE=0, MemReady tied 0, R-type Op=000000 -> State sequence 0,1,6,7,0 completes in 4 cycles.
